// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path: FSM states,
// bit-counter width and the supported oversampling ratios.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int BIT_CNT_W = 4;

    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

    function automatic logic presc_is_legal(input int unsigned p);
        return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Control bundle between the RX frame controller (master) and the
// sampler/checker/deserializer datapath (slave).
interface uart_rx_ctrl_if #(
    parameter int PRESC_WIDTH = 6
);
    import uart_rx_pkg::*;

    logic                   RX_IN;
    logic                   PAR_EN;
    logic [PRESC_WIDTH-1:0] Prescale;
    logic                   strt_glitch;
    logic                   par_err;
    logic                   stp_err;
    logic                   dat_samp_en;
    logic                   strt_chk_en;
    logic                   par_chk_en;
    logic                   stp_chk_en;
    logic                   deser_en;
    logic                   data_valid;
    logic [PRESC_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;

    modport master (
        input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
        output dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en,
               data_valid, edge_cnt, bit_cnt
    );

    modport slave (
        output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
        input  dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en,
               data_valid, edge_cnt, bit_cnt
    );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter. Both sit at zero while
// enable is low; bit_done flags the last edge of the current bit.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   enable,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic [PRESC_WIDTH-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]   bit_cnt,
    output logic                   bit_done
);

    logic [PRESC_WIDTH-1:0] edge_cnt_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;

    assign bit_done = (edge_cnt_q == prescale - PRESC_WIDTH'(1));

    // NOTE: non-blocking assignments keep every register reading the pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else if (!enable) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else if (bit_done) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= bit_cnt_q + BIT_CNT_W'(1);
        end else begin
            edge_cnt_q <= edge_cnt_q + PRESC_WIDTH'(1);
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: paces a frame from start detection to stop
// completion, strobes the checkers/deserializer and flags clean frames.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_ctrl_if.master bus
);

    rx_state_e              state_q, state_d;
    logic [PRESC_WIDTH-1:0] prescale_q, prescale_d;
    logic                   par_en_q, par_en_d;
    logic                   par_flag_q, par_flag_d;
    logic                   data_valid_q, data_valid_d;

    logic [PRESC_WIDTH-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   bit_done;
    logic                   cnt_en;
    logic [PRESC_WIDTH-1:0] chk_pt;
    logic                   at_chk;

    // Counters run only while the frame continues; entering or leaving IDLE zeroes them.
    assign cnt_en = (state_q != ST_IDLE) && (state_d != ST_IDLE);

    uart_rx_edge_bit_cnt #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (cnt_en),
        .prescale (prescale_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done)
    );

    // First edge where the sampler's majority vote has settled.
    assign chk_pt = (prescale_q >> 1) + PRESC_WIDTH'(2);
    assign at_chk = (edge_cnt == chk_pt);

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_flag_d   = par_flag_q;
        data_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!bus.RX_IN) begin
                    state_d    = ST_START;
                    // Unsupported ratios fall back to 8 so a frame always terminates.
                    prescale_d = presc_is_legal(32'(bus.Prescale)) ? bus.Prescale
                                                                   : PRESC_WIDTH'(PRESC_8);
                    par_en_d   = bus.PAR_EN;
                    par_flag_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = bus.strt_glitch ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done && (bit_cnt == BIT_CNT_W'(DATA_WIDTH))) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    par_flag_d = bus.par_err;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_d      = ST_IDLE;
                    data_valid_d = !bus.stp_err && !(par_en_q && par_flag_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            prescale_q   <= PRESC_WIDTH'(PRESC_8);
            par_en_q     <= 1'b0;
            par_flag_q   <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_flag_q   <= par_flag_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign bus.dat_samp_en = (state_q != ST_IDLE);
    assign bus.strt_chk_en = (state_q == ST_START)  && at_chk;
    assign bus.deser_en    = (state_q == ST_DATA)   && at_chk;
    assign bus.par_chk_en  = (state_q == ST_PARITY) && at_chk;
    assign bus.stp_chk_en  = (state_q == ST_STOP)   && at_chk;
    assign bus.data_valid  = data_valid_q;
    assign bus.edge_cnt    = edge_cnt;
    assign bus.bit_cnt     = bit_cnt;

endmodule
